ccrf_job_ingress: RTL and testbench
===================================

Name: ccrf_job_ingress

Overview:
Front end of the CCRF wrapper. It accepts raw job-request descriptors on an AXI-stream slave and decodes them into scratchpad-configuration commands or LDR image-stack jobs. Valid jobs are validated, packed into a parsed job word and buffered in a FIFO for the subtask scheduler. Every descriptor produces exactly one 32-bit status message on the response stream. It is the parametrised successor of the fixed 576-bit, 5-image request path.

Parameters:
DESC_W, 576, request descriptor width; must be at least 520.
ADDR_W, 64, address field width; descriptor word k occupies tdata[64k+63:64k].
MAX_IMAGES, 5, maximum input images per job; legal range 1..6 (words 1..MAX_IMAGES).
FIFO_DEPTH, 4, parsed-job FIFO entries; power of 2, at least 2.
JOB_W, derived (8+ADDR_W*(MAX_IMAGES+1)+40), parsed job width; localparam, not overridable.

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
incoming_job_requests_V_tvalid  in  1  descriptor valid
incoming_job_requests_V_tready  out  1  descriptor ready
incoming_job_requests_V_tdata  in  DESC_W  descriptor
jobs_to_schedule_V_tvalid  out  1  parsed job valid (FIFO not empty)
jobs_to_schedule_V_tready  in  1  scheduler ready
jobs_to_schedule_V_tdata  out  JOB_W  {count[7:0], height[15:0], width[15:0], inputs[MAX_IMAGES-1:0], output_addr, job_id[7:0]}, job_id in the LSBs
response_message_queue_V_tvalid  out  1  response valid
response_message_queue_V_tready  in  1  response ready
response_message_queue_V_tdata  out  32  {job_id[31:24], status[23:16], 8'd0, fifo_count[7:0]}
scratchpad_start  out  ADDR_W  configured scratchpad base
scratchpad_end  out  ADDR_W  configured scratchpad end
scratchpad_valid  out  1  scratchpad configured

Behaviour:
- Clock and reset: one clock, aclk; reset is asynchronous and active-low (aresetn).
- Reset values: all outputs 0, FIFO empty, FSM in IDLE. Reset mid-operation discards any captured descriptor and emits no response.
- Descriptor fields:
  - job_id = tdata[519:512].
  - word0 = output address; words 1..MAX_IMAGES = input addresses.
  - width = [463:448], height = [479:464], count = [487:480].
  - Config descriptor (job_id==0): start = word1, end = word2.
- FSM states IDLE, VALIDATE, PUSH, RESP.
- IDLE: tready=1. On tvalid&tready, register the descriptor and go to VALIDATE.
- VALIDATE (1 cycle), first matching rule wins:
  - job_id==0: if end>start (unsigned), load scratchpad regs, set scratchpad_valid, status=1 CONFIG_OK; else status=5 ERR_BAD_CONFIG, scratchpad regs unchanged. Go to RESP.
  - job_id!=0 and !scratchpad_valid: status=2 ERR_NO_SCRATCHPAD, go to RESP.
  - count==0 or count>MAX_IMAGES: status=3 ERR_BAD_COUNT, go to RESP.
  - width==0 or height==0: status=4 ERR_BAD_DIM, go to RESP.
  - Otherwise go to PUSH.
- PUSH:
  - Write to the FIFO only when fifo_count<FIFO_DEPTH; there is no same-cycle full bypass, so a pop while full frees a slot for the next cycle.
  - Stall in PUSH while full.
  - On write, status=0 ACCEPTED; go to RESP.
  - Input slots at index >= count are zeroed in the parsed job.
- RESP: response tvalid=1 with fifo_count sampled after the push. tdata is held stable until tready; on handshake go to IDLE. Latency from accept to response valid: 2 cycles when not stalled.
- FIFO:
  - Pop on jobs_to_schedule tvalid&tready.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- A re-config (job_id 0 again) overwrites the scratchpad regs; queued jobs are unaffected.

Optional Feature:
- CCRF_INGRESS_STATS_EN defined: adds outputs stat_accepted[31:0], stat_rejected[31:0] and stat_stall_cycles[31:0], all reset to 0.
  - accepted increments on status 0 or 1.
  - rejected increments on statuses 2-5.
  - stall_cycles increments on each cycle in PUSH with the FIFO full.
  - Counters saturate at all-ones.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package ccrf_ingress_pkg: status codes (ST_ACCEPTED=0 .. ST_ERR_BAD_CONFIG=5), FSM state enum, descriptor field offsets (JOB_ID_LSB=512, WIDTH_LSB=448, HEIGHT_LSB=464, COUNT_LSB=480), response field offsets.
- Sub-module ccrf_sync_fifo (WIDTH, DEPTH): synchronous FIFO with count output, instantiated for the parsed-job queue.

Test Plan:
- Reset with tvalid=1 held, then release: tready=0 during reset and =1 after; all outputs 0; no response until a handshake.
- Config job_id 0, start=1000, end=100000: response tdata=0x00010000, scratchpad_start=1000, scratchpad_end=100000, scratchpad_valid=1.
- Job before config (job_id 1): response status 2; FIFO stays empty; jobs_to_schedule tvalid stays 0.
- After config, job_id 1, output=100000000, inputs 10000..50000, 100x100, count 5: response 0x01000001; parsed job valid with the same fields.
- Count 6 with MAX_IMAGES=5: status 3. Width 0: status 4. Config with end<=start: status 5, previous scratchpad retained.
- FIFO_DEPTH=4 with scheduler tready=0: 5 jobs give 4 accepted responses (fifo_count 1..4), then the FSM stalls in PUSH. Raising tready for 1 cycle gives a fifth response with fifo_count=4. Pops drain job_ids in order.

Source files
------------

// File: rtl/ccrf_ingress_pkg.sv
// ccrf_ingress_pkg
// Shared definitions for the CCRF job-ingress front end:
//   - response status codes carried in the 32-bit response message
//   - ingress FSM state encoding
//   - bit offsets of the decoded descriptor fields
//   - bit offsets of the response message fields, plus a packing helper
package ccrf_ingress_pkg;

  // Response status codes
  localparam logic [7:0] ST_ACCEPTED          = 8'd0;
  localparam logic [7:0] ST_CONFIG_OK         = 8'd1;
  localparam logic [7:0] ST_ERR_NO_SCRATCHPAD = 8'd2;
  localparam logic [7:0] ST_ERR_BAD_COUNT     = 8'd3;
  localparam logic [7:0] ST_ERR_BAD_DIM       = 8'd4;
  localparam logic [7:0] ST_ERR_BAD_CONFIG    = 8'd5;

  // Ingress FSM
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_VALIDATE = 2'd1,
    S_PUSH     = 2'd2,
    S_RESP     = 2'd3
  } ingress_state_e;

  // Descriptor field offsets (LSB positions inside tdata)
  localparam int JOB_ID_LSB = 512;
  localparam int WIDTH_LSB  = 448;
  localparam int HEIGHT_LSB = 464;
  localparam int COUNT_LSB  = 480;

  // Response message field offsets
  localparam int RESP_JOB_ID_LSB = 24;
  localparam int RESP_STATUS_LSB = 16;
  localparam int RESP_COUNT_LSB  = 0;

  // Build a response word; bits [15:8] are always zero.
  function automatic logic [31:0] pack_response(input logic [7:0] job_id,
                                                input logic [7:0] status,
                                                input logic [7:0] fifo_count);
    logic [31:0] w_msg;
    w_msg = '0;
    w_msg[RESP_JOB_ID_LSB +: 8] = job_id;
    w_msg[RESP_STATUS_LSB +: 8] = status;
    w_msg[RESP_COUNT_LSB  +: 8] = fifo_count;
    return w_msg;
  endfunction

endpackage

// File: rtl/ccrf_sync_fifo.sv
// ccrf_sync_fifo
// Single-clock first-word-fall-through FIFO with an occupancy count.
// Writes while full and reads while empty are ignored.
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   i_wr_en    in   write request
//   i_wr_data  in   WIDTH  write data
//   i_rd_en    in   read (pop) request
//   o_rd_data  out  WIDTH  head entry (zero while empty)
//   o_empty    out  FIFO empty
//   o_full     out  FIFO full
//   o_count    out  clog2(DEPTH)+1  occupancy
module ccrf_sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign w_wr    = i_wr_en & ~o_full;
  assign w_rd    = i_rd_en & ~o_empty;

  // Storage is not reset; the head is masked while empty so the output
  // never shows stale or uninitialised entries.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ccrf_job_ingress.sv
// ccrf_job_ingress
// Front end of the CCRF wrapper. Accepts one job-request descriptor at a
// time, decodes it into either a scratchpad configuration (job_id 0) or an
// image-stack job, validates it, queues valid jobs in a parsed-job FIFO and
// answers every descriptor with exactly one 32-bit status message.
//
// Ports:
//   aclk, aresetn                       clock, asynchronous active-low reset
//   incoming_job_requests_V_*           descriptor AXI-stream slave (DESC_W)
//   jobs_to_schedule_V_*                parsed-job AXI-stream master (JOB_W)
//                                       {count, height, width, inputs,
//                                        output_addr, job_id}
//   response_message_queue_V_*          status AXI-stream master (32 bits)
//                                       {job_id, status, 8'd0, fifo_count}
//   scratchpad_start/_end/_valid        current scratchpad configuration
//
// Optional build macro CCRF_INGRESS_STATS_EN adds the saturating counters
// stat_accepted, stat_rejected and stat_stall_cycles (32 bits each).
module ccrf_job_ingress
  import ccrf_ingress_pkg::*;
#(
  parameter  int DESC_W     = 576,
  parameter  int ADDR_W     = 64,
  parameter  int MAX_IMAGES = 5,
  parameter  int FIFO_DEPTH = 4,
  localparam int JOB_W      = 8 + ADDR_W * (MAX_IMAGES + 1) + 40
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              incoming_job_requests_V_tvalid,
  output logic              incoming_job_requests_V_tready,
  input  logic [DESC_W-1:0] incoming_job_requests_V_tdata,
  output logic              jobs_to_schedule_V_tvalid,
  input  logic              jobs_to_schedule_V_tready,
  output logic [JOB_W-1:0]  jobs_to_schedule_V_tdata,
  output logic              response_message_queue_V_tvalid,
  input  logic              response_message_queue_V_tready,
  output logic [31:0]       response_message_queue_V_tdata,
  output logic [ADDR_W-1:0] scratchpad_start,
  output logic [ADDR_W-1:0] scratchpad_end,
  output logic              scratchpad_valid
`ifdef CCRF_INGRESS_STATS_EN
  ,
  output logic [31:0]       stat_accepted,
  output logic [31:0]       stat_rejected,
  output logic [31:0]       stat_stall_cycles
`endif
);

  // Words 1 and 2 are always captured because a config descriptor needs
  // both, even when MAX_IMAGES is 1.
  localparam int NWORDS = (MAX_IMAGES < 2) ? 3 : MAX_IMAGES + 1;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  genvar gi;

  ingress_state_e r_state;
  ingress_state_e w_state_next;

  logic              r_run;
  logic [7:0]        r_job_id;
  logic [15:0]       r_width;
  logic [15:0]       r_height;
  logic [7:0]        r_count;
  logic [ADDR_W-1:0] r_word [NWORDS];

  logic [ADDR_W-1:0] r_sp_start;
  logic [ADDR_W-1:0] r_sp_end;
  logic              r_sp_valid;
  logic [31:0]       r_resp_data;

  logic              w_capture;
  logic              w_fifo_wr;
  logic              w_fifo_rd;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CW-1:0]     w_fifo_count;
  logic [CW-1:0]     w_cnt_after;
  logic              w_resp_load;
  logic [7:0]        w_resp_status;
  logic              w_sp_load;
  logic [JOB_W-1:0]  w_job;
  logic [ADDR_W*MAX_IMAGES-1:0] w_inputs;
  logic              w_unused_desc;

  // Only a subset of the descriptor is decoded; the rest is reserved.
  assign w_unused_desc = ^incoming_job_requests_V_tdata;

  // r_run holds tready low while reset is asserted and for the first
  // edge after release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_run   <= 1'b1;
    end
  end

  always_comb begin
    w_state_next                    = r_state;
    w_capture                       = 1'b0;
    w_fifo_wr                       = 1'b0;
    w_resp_load                     = 1'b0;
    w_resp_status                   = ST_ACCEPTED;
    w_sp_load                       = 1'b0;
    incoming_job_requests_V_tready  = 1'b0;
    response_message_queue_V_tvalid = 1'b0;
    case (r_state)
      S_IDLE: begin
        incoming_job_requests_V_tready = r_run;
        if (r_run && incoming_job_requests_V_tvalid) begin
          w_capture    = 1'b1;
          w_state_next = S_VALIDATE;
        end
      end
      S_VALIDATE: begin
        w_resp_load  = 1'b1;
        w_state_next = S_RESP;
        if (r_job_id == 8'd0) begin
          if (r_word[2] > r_word[1]) begin
            w_sp_load     = 1'b1;
            w_resp_status = ST_CONFIG_OK;
          end else begin
            w_resp_status = ST_ERR_BAD_CONFIG;
          end
        end else if (!r_sp_valid) begin
          w_resp_status = ST_ERR_NO_SCRATCHPAD;
        end else if (r_count == 8'd0 || r_count > 8'(MAX_IMAGES)) begin
          w_resp_status = ST_ERR_BAD_COUNT;
        end else if (r_width == 16'd0 || r_height == 16'd0) begin
          w_resp_status = ST_ERR_BAD_DIM;
        end else begin
          w_resp_load  = 1'b0;
          w_state_next = S_PUSH;
        end
      end
      S_PUSH: begin
        // No full bypass: a pop while full only frees the slot next cycle.
        if (!w_fifo_full) begin
          w_fifo_wr     = 1'b1;
          w_resp_load   = 1'b1;
          w_resp_status = ST_ACCEPTED;
          w_state_next  = S_RESP;
        end
      end
      S_RESP: begin
        response_message_queue_V_tvalid = 1'b1;
        if (response_message_queue_V_tready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Descriptor capture
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_job_id <= '0;
      r_width  <= '0;
      r_height <= '0;
      r_count  <= '0;
      for (int k = 0; k < NWORDS; k++) r_word[k] <= '0;
    end else if (w_capture) begin
      r_job_id <= incoming_job_requests_V_tdata[JOB_ID_LSB +: 8];
      r_width  <= incoming_job_requests_V_tdata[WIDTH_LSB  +: 16];
      r_height <= incoming_job_requests_V_tdata[HEIGHT_LSB +: 16];
      r_count  <= incoming_job_requests_V_tdata[COUNT_LSB  +: 8];
      for (int k = 0; k < NWORDS; k++) begin
        r_word[k] <= incoming_job_requests_V_tdata[ADDR_W*k +: ADDR_W];
      end
    end
  end

  // Scratchpad configuration; a rejected config leaves it untouched.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_sp_start <= '0;
      r_sp_end   <= '0;
      r_sp_valid <= 1'b0;
    end else if (w_sp_load) begin
      r_sp_start <= r_word[1];
      r_sp_end   <= r_word[2];
      r_sp_valid <= 1'b1;
    end
  end

  assign scratchpad_start = r_sp_start;
  assign scratchpad_end   = r_sp_end;
  assign scratchpad_valid = r_sp_valid;

  // Input slots beyond the requested image count are zeroed.
  generate
    for (gi = 0; gi < MAX_IMAGES; gi++) begin : g_slot
      assign w_inputs[ADDR_W*gi +: ADDR_W] =
        (r_count > 8'(gi)) ? r_word[gi+1] : '0;
    end
  endgenerate

  assign w_job = {r_count, r_height, r_width, w_inputs, r_word[0], r_job_id};

  assign w_fifo_rd = jobs_to_schedule_V_tvalid & jobs_to_schedule_V_tready;

  ccrf_sync_fifo #(
    .WIDTH (JOB_W),
    .DEPTH (FIFO_DEPTH)
  ) u_job_fifo (
    .clk       (aclk),
    .rst_n     (aresetn),
    .i_wr_en   (w_fifo_wr),
    .i_wr_data (w_job),
    .i_rd_en   (jobs_to_schedule_V_tready),
    .o_rd_data (jobs_to_schedule_V_tdata),
    .o_empty   (w_fifo_empty),
    .o_full    (w_fifo_full),
    .o_count   (w_fifo_count)
  );

  assign jobs_to_schedule_V_tvalid = ~w_fifo_empty;

  // Occupancy as it will be once this cycle's push/pop have landed.
  assign w_cnt_after = w_fifo_count + CW'(w_fifo_wr) - CW'(w_fifo_rd);

  // The response is latched once and held until the handshake, so later
  // pops do not disturb the reported count.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_resp_data <= '0;
    end else if (w_resp_load) begin
      r_resp_data <= pack_response(r_job_id, w_resp_status, 8'(w_cnt_after));
    end
  end

  assign response_message_queue_V_tdata = r_resp_data;

`ifdef CCRF_INGRESS_STATS_EN
  logic [31:0] r_stat_accepted;
  logic [31:0] r_stat_rejected;
  logic [31:0] r_stat_stall;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_stat_accepted <= '0;
      r_stat_rejected <= '0;
      r_stat_stall    <= '0;
    end else begin
      if (w_resp_load) begin
        if (w_resp_status <= ST_CONFIG_OK) begin
          if (r_stat_accepted != '1) r_stat_accepted <= r_stat_accepted + 32'd1;
        end else begin
          if (r_stat_rejected != '1) r_stat_rejected <= r_stat_rejected + 32'd1;
        end
      end
      if (r_state == S_PUSH && w_fifo_full && r_stat_stall != '1) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
    end
  end

  assign stat_accepted     = r_stat_accepted;
  assign stat_rejected     = r_stat_rejected;
  assign stat_stall_cycles = r_stat_stall;
`endif

endmodule

// File: tb/tb_ccrf_job_ingress.sv
module tb_ccrf_job_ingress;

  localparam int DESC_W     = 576;
  localparam int ADDR_W     = 64;
  localparam int MAX_IMAGES = 5;
  localparam int FIFO_DEPTH = 4;
  localparam int JOB_W      = 8 + ADDR_W * (MAX_IMAGES + 1) + 40;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              in_tvalid = 1'b0;
  logic              in_tready;
  logic [DESC_W-1:0] in_tdata = '0;
  logic              job_tvalid;
  logic              job_tready = 1'b0;
  logic [JOB_W-1:0]  job_tdata;
  logic              resp_tvalid;
  logic              resp_tready = 1'b0;
  logic [31:0]       resp_tdata;
  logic [ADDR_W-1:0] sp_start;
  logic [ADDR_W-1:0] sp_end;
  logic              sp_valid;
`ifdef CCRF_INGRESS_STATS_EN
  logic [31:0]       st_acc;
  logic [31:0]       st_rej;
  logic [31:0]       st_stall;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard and reference model state
  logic [31:0]      resp_q[$];
  logic [JOB_W-1:0] job_q[$];
  logic             m_sp_valid = 1'b0;
  logic [63:0]      m_start = '0;
  logic [63:0]      m_end = '0;
  int               m_fifo_cnt = 0;

  ccrf_job_ingress #(
    .DESC_W     (DESC_W),
    .ADDR_W     (ADDR_W),
    .MAX_IMAGES (MAX_IMAGES),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .aclk                            (aclk),
    .aresetn                         (aresetn),
    .incoming_job_requests_V_tvalid  (in_tvalid),
    .incoming_job_requests_V_tready  (in_tready),
    .incoming_job_requests_V_tdata   (in_tdata),
    .jobs_to_schedule_V_tvalid       (job_tvalid),
    .jobs_to_schedule_V_tready       (job_tready),
    .jobs_to_schedule_V_tdata        (job_tdata),
    .response_message_queue_V_tvalid (resp_tvalid),
    .response_message_queue_V_tready (resp_tready),
    .response_message_queue_V_tdata  (resp_tdata),
    .scratchpad_start                (sp_start),
    .scratchpad_end                  (sp_end),
    .scratchpad_valid                (sp_valid)
`ifdef CCRF_INGRESS_STATS_EN
    ,
    .stat_accepted                   (st_acc),
    .stat_rejected                   (st_rej),
    .stat_stall_cycles               (st_stall)
`endif
  );

  always #5 aclk = ~aclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit (n_cmp=%0d)", n_cmp);
    $fatal(1);
  end

  // Descriptor builders; reserved bits are filled with junk on purpose.
  function automatic logic [DESC_W-1:0] make_job(input logic [7:0] id,
      input logic [63:0] out_addr, input logic [63:0] base,
      input logic [15:0] w, input logic [15:0] h, input logic [7:0] cnt);
    logic [DESC_W-1:0] d;
    d = '0;
    d[63:0] = out_addr;
    for (int k = 1; k <= MAX_IMAGES; k++) d[64*k +: 64] = base * k;
    d[447:384] = 64'hDEAD_BEEF_CAFE_F00D;
    d[463:448] = w;
    d[479:464] = h;
    d[487:480] = cnt;
    d[511:488] = 24'hA5A5A5;
    d[519:512] = id;
    d[575:520] = {56{1'b1}};
    return d;
  endfunction

  function automatic logic [DESC_W-1:0] make_cfg(input logic [63:0] s,
                                                 input logic [63:0] e);
    logic [DESC_W-1:0] d;
    d = '0;
    d[63:0]    = 64'h1234;
    d[127:64]  = s;
    d[191:128] = e;
    d[487:480] = 8'd3;
    return d;
  endfunction

  // Reference model: decides status, updates model state, pushes expectations.
  task automatic model_push(input logic [DESC_W-1:0] d);
    logic [7:0]       id, cnt, st;
    logic [15:0]      w, h;
    logic [JOB_W-1:0] job;
    logic [ADDR_W*MAX_IMAGES-1:0] ins;
    id  = d[519:512];
    cnt = d[487:480];
    w   = d[463:448];
    h   = d[479:464];
    if (id == 8'd0) begin
      if (d[191:128] > d[127:64]) begin
        st = 8'd1; m_sp_valid = 1'b1; m_start = d[127:64]; m_end = d[191:128];
      end else begin
        st = 8'd5;
      end
    end else if (!m_sp_valid) st = 8'd2;
    else if (cnt == 0 || cnt > MAX_IMAGES) st = 8'd3;
    else if (w == 0 || h == 0) st = 8'd4;
    else begin
      st = 8'd0;
      m_fifo_cnt++;
      for (int k = 1; k <= MAX_IMAGES; k++)
        ins[64*(k-1) +: 64] = (k <= cnt) ? d[64*k +: 64] : 64'd0;
      job = {cnt, h, w, ins, d[63:0], id};
      job_q.push_back(job);
    end
    resp_q.push_back({id, st, 8'h00, 8'(m_fifo_cnt)});
  endtask

  task automatic send_desc(input logic [DESC_W-1:0] d, output bit ok);
    int n;
    n = 0; ok = 1'b0;
    in_tdata = d; in_tvalid = 1'b1;
    while (!ok && n < 200) begin
      if (in_tready) ok = 1'b1;
      @(posedge aclk); #1; n++;
    end
    in_tvalid = 1'b0;
  endtask

  task automatic get_resp(output logic [31:0] data, output bit ok);
    int n;
    n = 0; ok = 1'b0; data = '0;
    resp_tready = 1'b1;
    while (!ok && n < 200) begin
      if (resp_tvalid) begin data = resp_tdata; ok = 1'b1; end
      @(posedge aclk); #1; n++;
    end
    resp_tready = 1'b0;
  endtask

  task automatic pop_job(output logic [JOB_W-1:0] data, output bit ok);
    int n;
    n = 0; ok = 1'b0; data = '0;
    job_tready = 1'b1;
    while (!ok && n < 200) begin
      if (job_tvalid) begin data = job_tdata; ok = 1'b1; end
      @(posedge aclk); #1; n++;
    end
    job_tready = 1'b0;
    if (ok) m_fifo_cnt--;
  endtask

  task automatic test_reset();
    bit seen;
    aresetn = 1'b0; in_tvalid = 1'b1; in_tdata = make_cfg(64'd5, 64'd10);
    resp_tready = 1'b1; job_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    n_cmp++; if (in_tready !== 1'b0) begin n_err++; $display("FAIL reset_tready got=%b want=0", in_tready); end
    n_cmp++; if (resp_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_resp_tvalid got=%b want=0", resp_tvalid); end
    n_cmp++; if (job_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_job_tvalid got=%b want=0", job_tvalid); end
    n_cmp++; if (resp_tdata !== 32'd0) begin n_err++; $display("FAIL reset_resp_tdata got=%h want=0", resp_tdata); end
    n_cmp++; if (job_tdata !== '0) begin n_err++; $display("FAIL reset_job_tdata got=%h want=0", job_tdata); end
    n_cmp++; if ({sp_valid, sp_start, sp_end} !== '0) begin n_err++; $display("FAIL reset_scratchpad got=%b/%0d/%0d want=0/0/0", sp_valid, sp_start, sp_end); end
    aresetn = 1'b1; in_tvalid = 1'b0; resp_tready = 1'b0; job_tready = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    n_cmp++; if (in_tready !== 1'b1) begin n_err++; $display("FAIL post_reset_tready got=%b want=1", in_tready); end
    seen = 1'b0;
    repeat (5) begin if (resp_tvalid) seen = 1'b1; @(posedge aclk); #1; end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL idle_no_response got=%b want=0", seen); end
    $display("[tb] reset: tready=%b sp_valid=%b", in_tready, sp_valid);
  endtask

  task automatic test_no_scratchpad();
    logic [DESC_W-1:0] d;
    logic [31:0] r, e;
    bit ok;
    d = make_job(8'd1, 64'd100000000, 64'd10000, 16'd100, 16'd100, 8'd5);
    send_desc(d, ok);
    model_push(d);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL nosp_send got=timeout want=handshake"); end
    get_resp(r, ok);
    e = resp_q.pop_front();
    n_cmp++; if (!ok || r !== e) begin n_err++; $display("FAIL nosp_resp got=%h ok=%b want=%h", r, ok, e); end
    n_cmp++; if (job_tvalid !== 1'b0) begin n_err++; $display("FAIL nosp_fifo_empty got=%b want=0", job_tvalid); end
    $display("[tb] job before config: resp=%h", r);
  endtask

  task automatic test_config();
    logic [DESC_W-1:0] d;
    logic [31:0] r, e;
    bit ok;
    d = make_cfg(64'd1000, 64'd100000);
    send_desc(d, ok);
    model_push(d);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL cfg_send got=timeout want=handshake"); end
    get_resp(r, ok);
    e = resp_q.pop_front();
    n_cmp++; if (!ok || r !== e) begin n_err++; $display("FAIL cfg_resp got=%h ok=%b want=%h", r, ok, e); end
    n_cmp++; if (r !== 32'h0001_0000) begin n_err++; $display("FAIL cfg_resp_const got=%h want=00010000", r); end
    n_cmp++; if ({sp_valid, sp_start, sp_end} !== {m_sp_valid, m_start, m_end}) begin
      n_err++; $display("FAIL cfg_regs got=%b/%0d/%0d want=%b/%0d/%0d", sp_valid, sp_start, sp_end, m_sp_valid, m_start, m_end);
    end
    $display("[tb] config: resp=%h start=%0d end=%0d", r, sp_start, sp_end);
  endtask

  task automatic test_job_accept();
    logic [DESC_W-1:0] d [2];
    logic [31:0] r, e;
    logic [JOB_W-1:0] j, ej;
    bit ok;
    d[0] = make_job(8'd1, 64'd100000000, 64'd10000, 16'd100, 16'd100, 8'd5);
    d[1] = make_job(8'd2, 64'd777, 64'd4096, 16'd640, 16'd480, 8'd1);
    for (int i = 0; i < 2; i++) begin
      send_desc(d[i], ok);
      model_push(d[i]);
      get_resp(r, ok);
      e = resp_q.pop_front();
      n_cmp++; if (!ok || r !== e) begin n_err++; $display("FAIL accept_resp[%0d] got=%h ok=%b want=%h", i, r, ok, e); end
      $display("[tb] job %0d: resp=%h", i + 1, r);
    end
    for (int i = 0; i < 2; i++) begin
      pop_job(j, ok);
      ej = job_q.pop_front();
      n_cmp++; if (!ok || j !== ej) begin n_err++; $display("FAIL accept_job[%0d] got=%h want=%h", i, j, ej); end
      $display("[tb] popped job id=%0d count=%0d", j[7:0], j[JOB_W-1 -: 8]);
    end
  endtask

  task automatic test_bad_fields();
    logic [DESC_W-1:0] d [6];
    logic [31:0] r, e;
    bit ok;
    d[0] = make_job(8'd3, 64'd1, 64'd2, 16'd10, 16'd10, 8'd6);
    d[1] = make_job(8'd4, 64'd1, 64'd2, 16'd10, 16'd10, 8'd0);
    d[2] = make_job(8'd5, 64'd1, 64'd2, 16'd0,  16'd10, 8'd2);
    d[3] = make_job(8'd6, 64'd1, 64'd2, 16'd10, 16'd0,  8'd2);
    d[4] = make_cfg(64'd5000, 64'd5000);
    d[5] = make_cfg(64'd9000, 64'd10);
    for (int i = 0; i < 6; i++) begin
      send_desc(d[i], ok);
      model_push(d[i]);
      get_resp(r, ok);
      e = resp_q.pop_front();
      n_cmp++; if (!ok || r !== e) begin n_err++; $display("FAIL bad_resp[%0d] got=%h ok=%b want=%h", i, r, ok, e); end
      $display("[tb] bad descriptor %0d: resp=%h", i, r);
    end
    n_cmp++; if ({sp_start, sp_end} !== {64'd1000, 64'd100000}) begin
      n_err++; $display("FAIL bad_cfg_retained got=%0d/%0d want=1000/100000", sp_start, sp_end);
    end
    n_cmp++; if (job_tvalid !== 1'b0) begin n_err++; $display("FAIL bad_fifo_empty got=%b want=0", job_tvalid); end
  endtask

  task automatic test_fifo_full();
    logic [DESC_W-1:0] d;
    logic [31:0] r, e;
    logic [JOB_W-1:0] j, ej;
    bit ok, seen;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      d = make_job(8'(10 + i), 64'(5000 * i), 64'(300 + i), 16'(20 + i), 16'(30 + i), 8'(1 + i));
      send_desc(d, ok);
      model_push(d);
      get_resp(r, ok);
      e = resp_q.pop_front();
      n_cmp++; if (!ok || r !== e) begin n_err++; $display("FAIL fill_resp[%0d] got=%h ok=%b want=%h", i, r, ok, e); end
      $display("[tb] fill job %0d: resp=%h", 10 + i, r);
    end
    d = make_job(8'd14, 64'd42, 64'd8, 16'd64, 16'd64, 8'd3);
    send_desc(d, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL stall_send got=timeout want=handshake"); end
    resp_tready = 1'b1;
    seen = 1'b0;
    repeat (8) begin if (resp_tvalid) seen = 1'b1; @(posedge aclk); #1; end
    resp_tready = 1'b0;
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL stall_no_resp got=%b want=0", seen); end
    pop_job(j, ok);
    ej = job_q.pop_front();
    n_cmp++; if (!ok || j !== ej) begin n_err++; $display("FAIL stall_pop got=%h want=%h", j, ej); end
    model_push(d);
    get_resp(r, ok);
    e = resp_q.pop_front();
    n_cmp++; if (!ok || r !== e) begin n_err++; $display("FAIL stall_resp got=%h ok=%b want=%h", r, ok, e); end
    $display("[tb] stalled job 14: resp=%h", r);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      pop_job(j, ok);
      ej = job_q.pop_front();
      n_cmp++; if (!ok || j !== ej) begin n_err++; $display("FAIL drain[%0d] got=%h want=%h", i, j, ej); end
      $display("[tb] drained job id=%0d", j[7:0]);
    end
    n_cmp++; if (job_tvalid !== 1'b0) begin n_err++; $display("FAIL drain_empty got=%b want=0", job_tvalid); end
  endtask

  initial begin
    test_reset();
    test_no_scratchpad();
    test_config();
    test_job_accept();
    test_bad_fields();
    test_fifo_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
